// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: input synchroniser and glitch filter, frame FSM
// with parity/stop/timeout checking, E0/F0 prefix decoding, and a
// first-word-fall-through FIFO of decoded scan codes.
module ps2_scan_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 3,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk_50,
  input  logic              RST,
  input  logic              SCL,
  input  logic              SDA,
  input  logic              rd_en,
  output logic [7:0]        data_out,
  output logic              is_ext,
  output logic              is_break,
  output logic              data_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int FILT_W = $clog2(FILTER_LEN) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic              scl_s1, scl_s2, sda_s1, sda_s2;
  logic              scl_filt, scl_filt_d, fe;
  logic [FILT_W-1:0] filt_cnt;
  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift, rx_byte;
  logic              bad, byte_ok;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              accept, ferr_set, timeout;
  logic              ext, brk, push, do_push, pop, ovf_set;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [9:0]        mem [FIFO_DEPTH];
  logic [9:0]        head;

  // Two-flop synchronisers; pins idle high so they reset to 1
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
    end
  end

  // Glitch filter: filtered SCL follows only after FILTER_LEN differing samples
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) begin
      scl_filt   <= 1'b1;
      scl_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      scl_filt_d <= scl_filt;
      if (scl_s2 == scl_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        scl_filt <= scl_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  assign fe = scl_filt_d & ~scl_filt;

  // Frame state register
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Frame next-state logic; timeout overrides any bit-level progress
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ferr_set  = 1'b0;
    timeout   = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    if (fe) begin
      case (state)
        IDLE:   if (!sda_s2) state_nxt = DATA;
                else         ferr_set  = 1'b1;
        DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          if (sda_s2 && !bad) accept   = 1'b1;
          else                ferr_set = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (timeout) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      ferr_set  = 1'b1;
    end
  end

  // Frame datapath: bit shifting, parity check, timeout counter, byte handoff
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) begin
      bit_cnt <= '0;
      shift   <= '0;
      bad     <= 1'b0;
      tmo_cnt <= '0;
      byte_ok <= 1'b0;
      rx_byte <= '0;
    end else begin
      if (fe) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            bad     <= 1'b0;
          end
          DATA: begin
            shift   <= {sda_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: bad <= ~(^shift ^ sda_s2);
          default: ;
        endcase
      end
      if (state == IDLE || fe)                     tmo_cnt <= '0;
      else if (tmo_cnt != TMO_W'(TIMEOUT_CYC))     tmo_cnt <= tmo_cnt + TMO_W'(1);
      byte_ok <= accept;
      if (accept) rx_byte <= shift;
    end
  end

  assign push = byte_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

  // Prefix tracking: E0/F0 arm flags, any real code or frame error clears them
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (ferr_set) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_ok) begin
      if (rx_byte == 8'hE0)      ext <= 1'b1;
      else if (rx_byte == 8'hF0) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign pop     = rd_en && data_valid;
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // FIFO storage; not reset, outputs are masked while empty
  always_ff @(posedge clk_50) begin
    if (do_push) mem[wr_ptr] <= {ext, brk, rx_byte};
  end

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge clk_50 or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      if (do_push && !pop)      count <= count + (ADDR_W+1)'(1);
      else if (pop && !do_push) count <= count - (ADDR_W+1)'(1);
      overflow  <= ovf_set  | (overflow  & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

  assign head       = mem[rd_ptr];
  assign data_valid = (count != '0);
  assign full       = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign data_out   = data_valid ? head[7:0] : 8'h00;
  assign is_break   = data_valid & head[8];
  assign is_ext     = data_valid & head[9];

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: bit-bangs PS/2 frames and checks
// decoded FIFO contents, flags, timeout, glitch rejection and reset.
module tb_ps2_scan_fifo;

  localparam int HALF  = 20;
  localparam int TMO   = 2000;
  localparam int FLEN  = 8;
  localparam int DEPTH = 8;

  logic       clk_50 = 1'b0;
  logic       RST = 1'b0;
  logic       SCL = 1'b1;
  logic       SDA = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       is_ext, is_break, data_valid, full, overflow, frame_err;
  logic [3:0] count;

  int test_cnt = 0;
  int fail_cnt = 0;
  int last_lat = -1;

  ps2_scan_fifo #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(3), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_50(clk_50), .RST(RST), .SCL(SCL), .SDA(SDA), .rd_en(rd_en),
    .data_out(data_out), .is_ext(is_ext), .is_break(is_break),
    .data_valid(data_valid), .full(full), .count(count),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  // 50 MHz system clock
  always #10 clk_50 = ~clk_50;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    test_cnt++;
    if (obs != exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send the first nbits of a frame (11 = whole frame); optionally raise
  // rd_en exactly in the push cycle that follows the stop-bit edge
  task automatic applyStimulus(input logic [7:0] code, input bit bad_par,
                               input int nbits, input bit pop_on_push);
    logic [10:0] frame;
    int fe_at, dv_at;
    frame = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    last_lat = -1;
    for (int b = 0; b < nbits; b++) begin
      SDA = frame[b];
      repeat (HALF) @(negedge clk_50);
      SCL = 1'b0;
      fe_at = -1;
      dv_at = -1;
      for (int i = 0; i < HALF; i++) begin
        @(negedge clk_50);
        if (b == 10) begin
          if (fe_at < 0 && dut.fe) fe_at = i;
          else if (fe_at >= 0) begin
            if (pop_on_push && i == fe_at + 1) rd_en = 1'b1;
            if (pop_on_push && i == fe_at + 2) rd_en = 1'b0;
            if (dv_at < 0 && data_valid) dv_at = i;
          end
        end
      end
      rd_en = 1'b0;
      SCL = 1'b1;
      if (b == 10 && fe_at >= 0 && dv_at >= 0) last_lat = dv_at - fe_at;
    end
    SDA = 1'b1;
    repeat (HALF) @(negedge clk_50);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    checkOutput(tag, data_out, exp);
    rd_en = 1'b1;
    @(negedge clk_50);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    @(negedge clk_50);
    err_clr = 1'b0;
    @(negedge clk_50);
  endtask

  // Safety net so a stuck design still ends the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", test_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    repeat (3) @(negedge clk_50);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_valid", data_valid, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_data", data_out, 0);
    RST = 1'b1;
    repeat (HALF) @(negedge clk_50);

    // Plain code and stop-edge to data_valid latency
    applyStimulus(8'h1C, 1'b0, 11, 1'b0);
    checkOutput("t1_latency", last_lat, 2);
    checkOutput("t1_count", count, 1);
    checkOutput("t1_ext", is_ext, 0);
    checkOutput("t1_brk", is_break, 0);
    checkOutput("t1_ferr", frame_err, 0);
    pop_expect("t1_data", 8'h1C);
    checkOutput("t1_empty", data_valid, 0);

    // Extended break sequence, then a plain make code
    applyStimulus(8'hE0, 1'b0, 11, 1'b0);
    applyStimulus(8'hF0, 1'b0, 11, 1'b0);
    checkOutput("t2_noprefix_push", count, 0);
    applyStimulus(8'h75, 1'b0, 11, 1'b0);
    applyStimulus(8'h75, 1'b0, 11, 1'b0);
    checkOutput("t2_count", count, 2);
    checkOutput("t2_ext1", is_ext, 1);
    checkOutput("t2_brk1", is_break, 1);
    pop_expect("t2_data1", 8'h75);
    checkOutput("t2_ext2", is_ext, 0);
    checkOutput("t2_brk2", is_break, 0);
    pop_expect("t2_data2", 8'h75);

    // Parity error
    applyStimulus(8'h1C, 1'b1, 11, 1'b0);
    checkOutput("t3_ferr", frame_err, 1);
    checkOutput("t3_count", count, 0);
    pulse_clear();
    checkOutput("t3_cleared", frame_err, 0);

    // Fill past capacity, then push and pop together while full
    for (int k = 1; k <= 9; k++) applyStimulus(8'(k), 1'b0, 11, 1'b0);
    checkOutput("t4_full", full, 1);
    checkOutput("t4_ovf", overflow, 1);
    checkOutput("t4_count", count, 8);
    checkOutput("t4_head", data_out, 8'h01);
    pulse_clear();
    checkOutput("t4_ovf_clr", overflow, 0);
    applyStimulus(8'h0A, 1'b0, 11, 1'b1);
    checkOutput("t4_pp_count", count, 8);
    checkOutput("t4_pp_ovf", overflow, 0);
    for (int k = 2; k <= 8; k++) pop_expect("t4_pop", 8'(k));
    pop_expect("t4_pop_last", 8'h0A);
    checkOutput("t4_drained", count, 0);
    checkOutput("t4_notfull", full, 0);

    // Timeout after 5 data bits, then a clean frame
    applyStimulus(8'h55, 1'b0, 6, 1'b0);
    repeat (TMO - 100) @(negedge clk_50);
    checkOutput("t5_early", frame_err, 0);
    repeat (200) @(negedge clk_50);
    checkOutput("t5_ferr", frame_err, 1);
    checkOutput("t5_count", count, 0);
    pulse_clear();
    applyStimulus(8'h2A, 1'b0, 11, 1'b0);
    checkOutput("t5_count2", count, 1);
    checkOutput("t5_ferr2", frame_err, 0);
    pop_expect("t5_data", 8'h2A);

    // Short SCL glitch in IDLE must not register as an edge
    SCL = 1'b0;
    repeat (FLEN - 2) @(negedge clk_50);
    SCL = 1'b1;
    repeat (HALF) @(negedge clk_50);
    checkOutput("t6_glitch_ferr", frame_err, 0);
    applyStimulus(8'h33, 1'b0, 11, 1'b0);
    checkOutput("t6_after_glitch", data_out, 8'h33);

    // Reset in the middle of a frame
    applyStimulus(8'h5A, 1'b0, 4, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge clk_50);
    checkOutput("t6_rst_count", count, 0);
    checkOutput("t6_rst_valid", data_valid, 0);
    checkOutput("t6_rst_data", data_out, 0);
    RST = 1'b1;
    repeat (HALF) @(negedge clk_50);
    applyStimulus(8'h5A, 1'b0, 11, 1'b0);
    checkOutput("t6_post_count", count, 1);
    checkOutput("t6_post_ferr", frame_err, 0);
    pop_expect("t6_post_data", 8'h5A);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
